csr_counter_bank: RTL

CSR_COUNTER_BANK -- requirements
Module: csr_counter_bank

---
 rtl/csr_counter_bank.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/csr_counter_bank.sv
// Machine/user performance counter bank: mcycle, minstret and NUM_HPM event
// counters, plus the mcountinhibit and mcounteren controls. It takes one CSR
// access per cycle and returns a registered response one cycle later.
module csr_counter_bank #(
   parameter int XLEN    = 64,
   parameter int NUM_HPM = 14,
   parameter int RET_W   = 2
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   csr_req_v,
   input  logic                                   csr_we,
   input  logic [11:0]                            csr_addr,
   input  logic [XLEN-1:0]                        csr_wdata,
   input  logic                                   priv_user,
   input  logic [RET_W-1:0]                       retire_cnt,
   input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
   output logic                                   csr_rvalid,
   output logic [XLEN-1:0]                        csr_rdata,
   output logic                                   csr_illegal
);

   // Implemented counter slots: bit 0 (cycle) and bits 2..2+NUM_HPM.
   localparam logic [63:0] MASK64   = ((64'd1 << (NUM_HPM + 3)) - 64'd1) & ~64'd2;
   localparam logic [31:0] CNT_MASK = MASK64[31:0];

   logic [63:0]     cnt [32];
   logic [31:0]     inhibit_q;
   logic [31:0]     enable_q;
   logic [63:0]     wdata_ext;
   logic [4:0]      idx;
   logic            is_hi;
   logic            ctr_ok;
   logic            is_ctr_m;
   logic            is_ctr_u;
   logic            is_inh;
   logic            is_en;
   logic            illegal_c;
   logic            wr_ok;
   logic            ctr_wr;
   logic            inh_wr;
   logic            en_wr;
   logic [63:0]     ctr_val;
   logic [63:0]     rd64;
   logic [XLEN-1:0] rdata_c;
   logic [63:0]     ctr_wr_val;

   // Address decode and access permission checks.
   always_comb begin
      idx      = csr_addr[4:0];
      is_hi    = csr_addr[7];
      ctr_ok   = ((csr_addr[7:5] == 3'b000) ||
                  ((XLEN == 32) && (csr_addr[7:5] == 3'b100))) && (idx != 5'd1);
      is_ctr_m = (csr_addr[11:8] == 4'hB) && ctr_ok;
      is_ctr_u = (csr_addr[11:8] == 4'hC) && ctr_ok;
      is_inh   = (csr_addr == 12'h320);
      is_en    = (csr_addr == 12'h306);
      illegal_c = 1'b0;
      if (!(is_ctr_m || is_ctr_u || is_inh || is_en))
         illegal_c = 1'b1;
      if (is_ctr_u && csr_we)
         illegal_c = 1'b1;
      if (priv_user && (is_ctr_m || is_inh || is_en))
         illegal_c = 1'b1;
      if (priv_user && is_ctr_u && !enable_q[idx])
         illegal_c = 1'b1;
   end

   // Read mux (pre-write values) and write data formation.
   always_comb begin
      wdata_ext = '0;
      wdata_ext[XLEN-1:0] = csr_wdata;
      ctr_val = cnt[idx];
      rd64 = '0;
      if (is_inh)
         rd64 = {32'd0, inhibit_q};
      else if (is_en)
         rd64 = {32'd0, enable_q};
      else if (is_ctr_m || is_ctr_u)
         rd64 = ((XLEN == 32) && is_hi) ? {32'd0, ctr_val[63:32]} : ctr_val;
      rdata_c = illegal_c ? '0 : rd64[XLEN-1:0];
      wr_ok  = csr_req_v && csr_we && !illegal_c;
      ctr_wr = wr_ok && is_ctr_m;
      inh_wr = wr_ok && is_inh;
      en_wr  = wr_ok && is_en;
      ctr_wr_val = wdata_ext;
      // A half write keeps the other half's pre-increment value.
      if (XLEN == 32)
         ctr_wr_val = is_hi ? {wdata_ext[31:0], ctr_val[31:0]}
                            : {ctr_val[63:32], wdata_ext[31:0]};
   end

   for (genvar g = 0; g < 32; g++) begin : g_cnt
      if ((g == 0) || (g == 2) || ((g >= 3) && (g < 3 + NUM_HPM))) begin : g_impl
         logic [63:0] q;
         logic [63:0] inc_amt;
         if (g == 0) begin : g_cyc
            assign inc_amt = 64'd1;
         end else if (g == 2) begin : g_ret
            assign inc_amt = 64'(retire_cnt);
         end else begin : g_hpm
            assign inc_amt = {63'd0, hpm_event[g-3]};
         end
         // Counter update; a CSR write takes priority over the increment.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
               q <= '0;
            else if (ctr_wr && (idx == 5'(g)))
               q <= ctr_wr_val;
            else if (!inhibit_q[g])
               q <= q + inc_amt;
         end
         assign cnt[g] = q;
      end else begin : g_none
         assign cnt[g] = '0;
      end
   end

   // Inhibit and enable controls, with unimplemented bits held at zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inhibit_q <= '0;
         enable_q  <= '0;
      end else begin
         if (inh_wr)
            inhibit_q <= wdata_ext[31:0] & CNT_MASK;
         if (en_wr)
            enable_q <= wdata_ext[31:0] & CNT_MASK;
      end
   end

   // Registered response, valid one cycle after the request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         csr_rvalid  <= 1'b0;
         csr_rdata   <= '0;
         csr_illegal <= 1'b0;
      end else begin
         csr_rvalid  <= csr_req_v;
         csr_rdata   <= csr_req_v ? rdata_c : '0;
         csr_illegal <= csr_req_v && illegal_c;
      end
   end

endmodule
